ula_ctrl: RTL

ULA_CTRL -- requirements
Module: ula_ctrl

---
 rtl/ula_ctrl.sv | 122 ++++++++++++
 1 files changed

// File: rtl/ula_ctrl.sv
// ula_ctrl: instruction sequencer for an external 8-bit ALU with 4 registers.
// Optional illegal-opcode trap enabled by defining ULA_CTRL_TRAP_EN.
module ula_ctrl #(
    parameter int NREGS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       instr_valid,
    input  logic [7:0] instr,
    output logic       instr_ready,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [3:0] alu_sel,
    input  logic [7:0] alu_s,
    input  logic       alu_zero,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic       zero_flag,
    output logic       err
);

    typedef enum logic [2:0] {
        IDLE,
        IMM,
        EXEC,
        RESP,
        TRAP
    } state_t;

    localparam logic [3:0] OP_LAST_ALU = 4'd9;
    localparam logic [3:0] OP_LDI      = 4'd10;

    state_t     state;
    logic [7:0] regs [NREGS];
    logic [1:0] ra_q;
    logic [3:0] op;
    logic [1:0] ra;
    logic [1:0] rb;
    logic       accept;

    assign op     = instr[7:4];
    assign ra     = instr[3:2];
    assign rb     = instr[1:0];
    assign accept = instr_valid & instr_ready;

    // Handshake outputs follow the state register directly.
    assign instr_ready = (state == IDLE) || (state == IMM);
    assign res_valid   = (state == RESP);

`ifndef ULA_CTRL_TRAP_EN
    assign err = 1'b0;
`endif

    // Sequencer: decode, operand fetch, write-back and response handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            ra_q      <= 2'd0;
            alu_a     <= 8'h00;
            alu_b     <= 8'h00;
            alu_sel   <= 4'h0;
            res_data  <= 8'h00;
            zero_flag <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= 8'h00;
            end
`ifdef ULA_CTRL_TRAP_EN
            err <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (op <= OP_LAST_ALU) begin
                            alu_a   <= regs[ra];
                            alu_b   <= regs[rb];
                            alu_sel <= op;
                            ra_q    <= ra;
                            state   <= EXEC;
                        end else if (op == OP_LDI) begin
                            ra_q  <= ra;
                            state <= IMM;
                        end else begin
`ifdef ULA_CTRL_TRAP_EN
                            err   <= 1'b1;
                            state <= TRAP;
`else
                            state <= IDLE;
`endif
                        end
                    end
                end
                IMM: begin
                    if (accept) begin
                        regs[ra_q] <= instr;
                        res_data   <= instr;
                        state      <= RESP;
                    end
                end
                EXEC: begin
                    regs[ra_q] <= alu_s;
                    res_data   <= alu_s;
                    zero_flag  <= alu_zero;
                    state      <= RESP;
                end
                RESP: begin
                    if (res_ready) begin
                        state <= IDLE;
                    end
                end
                TRAP: begin
                    state <= TRAP;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
